// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Loadable command issuer for the accumulator ALU. A host fills a program buffer with
// (opcode, operand) entries, pulses start, and the block replays the entries in order
// over a valid/ready handshake, then pulses done.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   load_en/op/arg        append one entry at the load pointer (IDLE only, dropped when full)
//   clear                 empty the program buffer (IDLE only, wins over load_en)
//   start                 replay the program (IDLE only)
//   alu_ready             ALU accepts the presented command this cycle
//   opcode, operand       command to the ALU; NOOP/0 whenever cmd_valid is low
//   cmd_valid             command valid
//   busy                  high in ISSUE and FIN
//   done                  one-cycle completion pulse
//   prog_len, full        number of loaded entries, buffer full flag
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [3:0]       load_op,
    input  logic [WIDTH-1:0] load_arg,
    input  logic             clear,
    input  logic             start,
    input  logic             alu_ready,
    output logic [3:0]       opcode,
    output logic [WIDTH-1:0] operand,
    output logic             cmd_valid,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      prog_len,
    output logic             full
);

    typedef enum logic [1:0] {StIdle, StIssue, StFin} state_e;

    state_e           state;
    logic [AW-1:0]    rd_ptr;
    logic [3:0]       mem_op  [DEPTH];
    logic [WIDTH-1:0] mem_arg [DEPTH];

    logic             load_ok;
    logic [AW:0]      eff_len;
    logic [AW:0]      len_inc;
    logic             at_last;
    logic             mem_we;
    logic [3:0]       first_op;
    logic [WIDTH-1:0] first_arg;
    logic [AW-1:0]    rd_next;

    always_comb begin
        load_ok = load_en && !full && !clear;
        len_inc = prog_len + (AW+1)'(1);
        // Effective length seen by start: includes a load accepted in the same cycle.
        eff_len = clear ? '0 : (load_ok ? len_inc : prog_len);
        at_last = ({1'b0, rd_ptr} == (prog_len - (AW+1)'(1)));
        mem_we  = !rst && (state == StIdle) && load_ok;
        rd_next = rd_ptr + AW'(1);
        // Entry 0 may be the one being written this very cycle; bypass the buffer.
        if (load_ok && (prog_len == '0)) begin
            first_op  = load_op;
            first_arg = load_arg;
        end else begin
            first_op  = mem_op[0];
            first_arg = mem_arg[0];
        end
    end

    // Program storage; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_op[prog_len[AW-1:0]]  <= load_op;
            mem_arg[prog_len[AW-1:0]] <= load_arg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            rd_ptr    <= '0;
            prog_len  <= '0;
            full      <= 1'b0;
            opcode    <= 4'b0000;
            operand   <= '0;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (clear) begin
                        prog_len <= '0;
                        full     <= 1'b0;
                    end else if (load_ok) begin
                        prog_len <= len_inc;
                        full     <= (len_inc == (AW+1)'(DEPTH));
                    end
                    if (start) begin
                        busy <= 1'b1;
                        if (eff_len != '0) begin
                            state     <= StIssue;
                            rd_ptr    <= '0;
                            cmd_valid <= 1'b1;
                            opcode    <= first_op;
                            operand   <= first_arg;
                        end else begin
                            state <= StFin;
                            done  <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (cmd_valid && alu_ready) begin
                        if (at_last) begin
                            state     <= StFin;
                            cmd_valid <= 1'b0;
                            opcode    <= 4'b0000;
                            operand   <= '0;
                            done      <= 1'b1;
                        end else begin
                            rd_ptr  <= rd_next;
                            opcode  <= mem_op[rd_next];
                            operand <= mem_arg[rd_next];
                        end
                    end
                end
                StFin: begin
                    state <= StIdle;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= StIdle;
                    cmd_valid <= 1'b0;
                    opcode    <= 4'b0000;
                    operand   <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_op;
    logic [15:0] load_arg;
    logic        clear;
    logic        start;
    logic        alu_ready;
    logic [3:0]  opcode;
    logic [15:0] operand;
    logic        cmd_valid;
    logic        busy;
    logic        done;
    logic [4:0]  prog_len;
    logic        full;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  exp_op  [16];
    logic [15:0] exp_arg [16];

    alu_cmd_sequencer #(.WIDTH(16), .DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_op   (load_op),
        .load_arg  (load_arg),
        .clear     (clear),
        .start     (start),
        .alu_ready (alu_ready),
        .opcode    (opcode),
        .operand   (operand),
        .cmd_valid (cmd_valid),
        .busy      (busy),
        .done      (done),
        .prog_len  (prog_len),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input int idx, input logic [3:0] op, input logic [15:0] arg);
        load_en  = 1'b1;
        load_op  = op;
        load_arg = arg;
        tick();
        load_en  = 1'b0;
        exp_op[idx]  = op;
        exp_arg[idx] = arg;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_vld"}, 32'(cmd_valid), 0);
        check_eq({tag, "_op"}, 32'(opcode), 0);
        check_eq({tag, "_arg"}, 32'(operand), 0);
    endtask

    // Start a run and check every presented command. The ALU stalls for stall_len cycles
    // while entry stall_at is presented; disturb pulses load_en/clear/start during ISSUE.
    task automatic run_prog(input int n, input int stall_at, input int stall_len,
                            input bit disturb);
        int idx    = 0;
        int stalls = 0;
        int cyc    = 0;
        start     = 1'b1;
        alu_ready = 1'b1;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        while (idx < n && cyc < 64) begin
            check_eq($sformatf("vld%0d", idx), 32'(cmd_valid), 1);
            check_eq($sformatf("op%0d", idx), 32'(opcode), 32'(exp_op[idx]));
            check_eq($sformatf("arg%0d", idx), 32'(operand), 32'(exp_arg[idx]));
            check_eq($sformatf("busy%0d", idx), 32'(busy), 1);
            if (disturb && idx == 1) begin
                load_en  = 1'b1;
                load_op  = 4'h7;
                load_arg = 16'hBEEF;
                clear    = 1'b1;
                start    = 1'b1;
            end
            alu_ready = !(idx == stall_at && stalls < stall_len);
            tick();
            load_en = 1'b0;
            clear   = 1'b0;
            start   = 1'b0;
            cyc++;
            if (alu_ready) idx++;
            else stalls++;
        end
        alu_ready = 1'b1;
        check_eq("run_cycles", 32'(cyc), 32'(n + stall_len));
        check_eq("fin_done", 32'(done), 1);
        check_eq("fin_busy", 32'(busy), 1);
        check_idle_outputs("fin");
        tick();
        check_eq("post_done", 32'(done), 0);
        check_eq("post_busy", 32'(busy), 0);
        check_idle_outputs("post");
    endtask

    initial begin
        rst       = 1'b1;
        load_en   = 1'b0;
        load_op   = '0;
        load_arg  = '0;
        clear     = 1'b0;
        start     = 1'b0;
        alu_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_idle_outputs("rst");
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_len", 32'(prog_len), 0);
        check_eq("rst_full", 32'(full), 0);

        // Basic three-entry program
        load_entry(0, 4'b0001, 16'd0);
        load_entry(1, 4'b0010, 16'd5);
        load_entry(2, 4'b0010, 16'd3);
        check_eq("len3", 32'(prog_len), 3);
        run_prog(3, -1, 0, 1'b0);
        check_eq("len3_after", 32'(prog_len), 3);

        // Two-cycle stall on entry 1
        run_prog(3, 1, 2, 1'b0);

        // Replay with load/clear/start pulsed mid-run
        run_prog(3, -1, 0, 1'b1);
        check_eq("len3_disturb", 32'(prog_len), 3);

        // Fill to capacity, including undefined opcodes
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_len", 32'(prog_len), 0);
        for (int i = 0; i < 16; i++) begin
            load_entry(i, 4'(i), 16'(i * 257 + 7));
        end
        check_eq("full16", 32'(full), 1);
        check_eq("len16", 32'(prog_len), 16);
        load_en  = 1'b1;
        load_op  = 4'hF;
        load_arg = 16'hDEAD;
        tick();
        load_en = 1'b0;
        check_eq("len16_ovf", 32'(prog_len), 16);
        run_prog(16, -1, 0, 1'b0);

        // clear together with load_en: clear wins
        clear    = 1'b1;
        load_en  = 1'b1;
        load_op  = 4'h2;
        load_arg = 16'h0011;
        tick();
        clear   = 1'b0;
        load_en = 1'b0;
        check_eq("clrld_len", 32'(prog_len), 0);
        check_eq("clrld_full", 32'(full), 0);

        // start on an empty buffer
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("empty_done", 32'(done), 1);
        check_eq("empty_busy", 32'(busy), 1);
        check_idle_outputs("empty");
        tick();
        check_eq("empty_done2", 32'(done), 0);
        check_eq("empty_busy2", 32'(busy), 0);

        // start with a load in the same cycle on an empty buffer
        load_en  = 1'b1;
        load_op  = 4'h9;
        load_arg = 16'h1234;
        exp_op[0]  = 4'h9;
        exp_arg[0] = 16'h1234;
        run_prog(1, -1, 0, 1'b0);
        check_eq("samecyc_len", 32'(prog_len), 1);

        // Reset during the second of four issues
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load_entry(0, 4'h2, 16'd1);
        load_entry(1, 4'h3, 16'd2);
        load_entry(2, 4'h4, 16'd3);
        load_entry(3, 4'h5, 16'd4);
        start     = 1'b1;
        alu_ready = 1'b1;
        tick();
        start = 1'b0;
        check_eq("ab_op0", 32'(opcode), 2);
        tick();
        check_eq("ab_op1", 32'(opcode), 3);
        check_eq("ab_arg1", 32'(operand), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("ab");
        check_eq("ab_busy", 32'(busy), 0);
        check_eq("ab_len", 32'(prog_len), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("ab_done", 32'(done), 1);
        check_eq("ab_vld2", 32'(cmd_valid), 0);
        tick();
        check_eq("ab_vld3", 32'(cmd_valid), 0);
        check_eq("ab_busy3", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command issuer that drives the accumulator ALU's opcode/operand inputs, replacing hand-written stimulus with a loadable program. A host writes up to DEPTH (opcode, operand) entries into an internal program buffer, pulses `start`, and the block replays the entries in order to the ALU with a valid/ready handshake, then signals completion. It sits upstream of the ALU breadboard, on the opposite end of the ALU's opcode/operand interface.

## Interface
- WIDTH, 16, operand width; matches ALU data width
- DEPTH, 16, program buffer entries
- AW, 4, pointer width, log2(DEPTH)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- load_en  in  1  write one entry at the load pointer
- load_op  in  4  opcode to store (ALU opcode encoding: 0000 NOOP, 0001 RESET, 0010 ADD, 0011 SUB, 0100 MULT, 0101 DIV, 0110 AND, 0111 OR, 1000 NOT, 1001 XOR)
- load_arg  in  WIDTH  operand to store
- clear  in  1  empty the program buffer (honoured only in IDLE)
- start  in  1  begin replaying the program
- alu_ready  in  1  ALU accepts the presented command this cycle
- opcode  out  4  command opcode to ALU
- operand  out  WIDTH  command operand to ALU
- cmd_valid  out  1  opcode/operand valid
- busy  out  1  high in ISSUE and FIN
- done  out  1  one-cycle completion pulse
- prog_len  out  AW+1  number of loaded entries, 0..DEPTH
- full  out  1  prog_len == DEPTH

## Operation
- States: IDLE, ISSUE, FIN. Reset state IDLE.
- Reset: prog_len=0, load/read pointers=0, opcode=0000, operand=0, cmd_valid=0, busy=0, done=0, full=0. Buffer contents need not be cleared. Reset mid-ISSUE aborts immediately; no further commands.
- IDLE:
  - load_en && !full: mem[prog_len] ← {load_op, load_arg}; prog_len+1.
  - load_en && full: ignored, no wrap, prog_len unchanged.
  - clear: prog_len ← 0. clear together with load_en: clear wins, load dropped.
  - start with effective length L>0 → ISSUE, read pointer=0. L counts a load accepted in the same cycle, so that entry is included.
  - start with L==0 → FIN directly, with no command issued.
- ISSUE: cmd_valid=1, opcode/operand = mem[rd_ptr]. Transfer occurs when cmd_valid && alu_ready at a rising edge.
  - Transfer with rd_ptr < L-1: rd_ptr+1.
  - Transfer with rd_ptr == L-1: → FIN.
  - While alu_ready=0: hold opcode/operand/cmd_valid stable.
  - load_en, clear and start are ignored in ISSUE and FIN.
- FIN: done=1, cmd_valid=0, opcode=0000, operand=0. Next cycle → IDLE.
- The program is retained after completion. A second start replays it unchanged.
- Opcodes are passed through verbatim. Invalid codes 1010–1111 are issued as-is, with no checking.
- Whenever cmd_valid=0, opcode=0000 (NOOP) and operand=0, so the ALU holds its accumulator.

## Timing
- All outputs are registered.
- start sampled at edge N → cmd_valid=1 with entry 0 during cycle N+1.
- Throughput is 1 command per cycle while alu_ready=1. L entries with alu_ready held high: cmd_valid is high for exactly L cycles.
- The final transfer at edge E → done=1 and busy=1 during cycle E+1 → busy=0 and done=0 from E+2.
- start with L==0 at edge N → done=1 during cycle N+1.
- A load at edge N is reflected in prog_len and full from cycle N+1.
- Minimum start-to-start for back-to-back runs: L+2 cycles.

## Test plan
- Reset, load {0001,0}, {0010,5}, {0010,3}, start, alu_ready=1 → cmd_valid high 3 consecutive cycles showing (0001,0), (0010,5), (0010,3); done pulse one cycle later; busy low after; prog_len=3 throughout.
- Same program with alu_ready=0 for 2 cycles while entry 1 is presented → (0010,5) held stable 3 cycles, no entry skipped or duplicated, done delayed by exactly 2 cycles.
- Load 16 entries → full=1, prog_len=16; 17th load_en → prog_len stays 16; run → 16 transfers, last is mem[15].
- start with empty buffer → no cmd_valid, done=1 in the next cycle; clear with load_en in IDLE → prog_len=0.
- rst asserted during the 2nd of 4 issues → next cycle cmd_valid=0, opcode=0000, busy=0, prog_len=0; subsequent start → immediate done, no commands.
- Run completes, then start again without reloading → identical command sequence; load_en/clear/start pulsed during ISSUE → no effect on sequence or prog_len.
